// File: rtl/mem_access_unit_if.sv
// Bundles the EX/MEM inputs and MEM/WB outputs of the memory access unit.
// The slave modport is the unit's view; master is the upstream pipeline's.
interface mem_access_unit_if;
    logic        i_valid;
    logic [31:0] i_result;
    logic        i_zero;
    logic [31:0] i_read_data2;
    logic [4:0]  i_write_reg;
    logic [1:0]  i_WB_control;
    logic [2:0]  i_MEM_control;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] i_branch_pc;

    logic        o_stall;
    logic        o_branch;
    logic [31:0] o_branch_pc;
    logic        o_misalign;
    logic        o_valid;
    logic [4:0]  o_write_reg;
    logic [31:0] o_write_data;
    logic [31:0] o_result;
    logic [1:0]  o_WB_control;

    modport master (
        output i_valid, i_result, i_zero, i_read_data2, i_write_reg,
               i_WB_control, i_MEM_control, i_size, i_unsigned, i_branch_pc,
        input  o_stall, o_branch, o_branch_pc, o_misalign, o_valid,
               o_write_reg, o_write_data, o_result, o_WB_control
    );

    modport slave (
        input  i_valid, i_result, i_zero, i_read_data2, i_write_reg,
               i_WB_control, i_MEM_control, i_size, i_unsigned, i_branch_pc,
        output o_stall, o_branch, o_branch_pc, o_misalign, o_valid,
               o_write_reg, o_write_data, o_result, o_WB_control
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: data memory with fixed-latency stalls, sub-word
// load/store lanes, branch resolution and the MEM/WB register.
module mem_access_unit #(
    parameter int DEPTH_LOG2 = 8,
    parameter int MEM_LAT    = 2
) (
    input logic               i_clk,
    input logic               i_rst_n,
    mem_access_unit_if.slave  bus
);
    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [2:0] CNT_INIT = (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : 3'd0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        valid_q, valid_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic [31:0] write_data_q, write_data_d;
    logic [31:0] result_q, result_d;
    logic [1:0]  wb_q, wb_d;

    logic [31:0] mem [0:DEPTH-1];

    logic                  mem_read, mem_write, is_load;
    logic                  access, misalign, mem_op;
    logic                  stall, complete, we;
    logic [DEPTH_LOG2-1:0] widx;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           load_data;

    assign mem_write = bus.i_MEM_control[2];
    assign mem_read  = bus.i_MEM_control[1];
    // A store wins over a simultaneous read, so only a pure read is a load.
    assign is_load   = mem_read & ~mem_write;
    assign access    = bus.i_valid & (mem_read | mem_write);
    assign misalign  = access & (((bus.i_size == 2'b01) & bus.i_result[0]) |
                                 (bus.i_size[1] & (bus.i_result[1:0] != 2'b00)));
    assign mem_op    = access & ~misalign;
    assign widx      = bus.i_result[DEPTH_LOG2+1:2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        if (MEM_LAT == 1) begin
            complete = mem_op;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_op) begin
                        stall   = 1'b1;
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
                BUSY: begin
                    stall = (cnt_q != 3'd0);
                    if (cnt_q == 3'd0) begin
                        complete = mem_op;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            endcase
        end
    end

    // Byte enables per lane: byte picks one lane, half picks a lane pair.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign be[gi] = bus.i_size[1] |
                        (bus.i_size[0] ? (bus.i_result[1] == LANE[1])
                                       : (bus.i_result[1:0] == LANE));
    end

    always_comb begin
        case (bus.i_size)
            2'b00:   wdata = {4{bus.i_read_data2[7:0]}};
            2'b01:   wdata = {2{bus.i_read_data2[15:0]}};
            default: wdata = bus.i_read_data2;
        endcase
    end

    assign we      = complete & mem_write & i_rst_n;
    assign rd_word = mem[widx];
    assign rd_byte = rd_word[{bus.i_result[1:0], 3'b000} +: 8];
    assign rd_half = bus.i_result[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (bus.i_size)
            2'b00:   load_data = bus.i_unsigned ? {24'd0, rd_byte}
                                                : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_data = bus.i_unsigned ? {16'd0, rd_half}
                                                : {{16{rd_half[15]}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    // Stalled or misaligned edges load a bubble; all other edges advance.
    always_comb begin
        valid_d      = 1'b0;
        write_reg_d  = 5'd0;
        write_data_d = 32'd0;
        result_d     = 32'd0;
        wb_d         = 2'b00;
        if (!stall && !misalign) begin
            valid_d      = bus.i_valid;
            write_reg_d  = bus.i_write_reg;
            result_d     = bus.i_result;
            wb_d         = bus.i_WB_control;
            write_data_d = (complete && is_load) ? load_data : 32'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            valid_q      <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= 32'd0;
            result_q     <= 32'd0;
            wb_q         <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            result_q     <= result_d;
            wb_q         <= wb_d;
        end
    end

    // Memory contents survive reset; the write is masked while reset is held.
    always_ff @(posedge i_clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign bus.o_stall      = stall;
    assign bus.o_misalign   = misalign;
    assign bus.o_branch     = bus.i_valid & bus.i_MEM_control[0] & bus.i_zero;
    assign bus.o_branch_pc  = bus.i_branch_pc;
    assign bus.o_valid      = valid_q;
    assign bus.o_write_reg  = write_reg_q;
    assign bus.o_write_data = write_data_q;
    assign bus.o_result     = result_q;
    assign bus.o_WB_control = wb_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: one instance per latency 1..4 sharing stimulus,
// a vector table, hand sequences and random ops against a byte-level model.
module tb_mem_access_unit;
    localparam int NDUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [2:0]  mctl;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] data;
        logic        zero;
        logic [4:0]  wreg;
        logic [1:0]  wb;
        logic [31:0] bpc;
    } op_t;

    typedef struct {
        op_t         op;
        logic        exp_mis;
        logic        exp_br;
        logic        exp_valid;
        logic [31:0] exp_wd;
        int          exp_st;
    } vec_t;

    logic        t_valid, t_zero, t_uns;
    logic [31:0] t_result, t_data, t_bpc;
    logic [4:0]  t_wreg;
    logic [1:0]  t_wb, t_size;
    logic [2:0]  t_mctl;

    logic [NDUT-1:0]       stall_a, mis_a, br_a, valid_a;
    logic [NDUT-1:0][31:0] bpc_a, wd_a, res_a;
    logic [NDUT-1:0][4:0]  wreg_a;
    logic [NDUT-1:0][1:0]  wb_a;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        mem_access_unit_if bus ();
        assign bus.i_valid       = t_valid;
        assign bus.i_result      = t_result;
        assign bus.i_zero        = t_zero;
        assign bus.i_read_data2  = t_data;
        assign bus.i_write_reg   = t_wreg;
        assign bus.i_WB_control  = t_wb;
        assign bus.i_MEM_control = t_mctl;
        assign bus.i_size        = t_size;
        assign bus.i_unsigned    = t_uns;
        assign bus.i_branch_pc   = t_bpc;

        mem_access_unit #(.DEPTH_LOG2(8), .MEM_LAT(gi + 1)) dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .bus     (bus)
        );

        assign stall_a[gi] = bus.o_stall;
        assign mis_a[gi]   = bus.o_misalign;
        assign br_a[gi]    = bus.o_branch;
        assign bpc_a[gi]   = bus.o_branch_pc;
        assign valid_a[gi] = bus.o_valid;
        assign wreg_a[gi]  = bus.o_write_reg;
        assign wd_a[gi]    = bus.o_write_data;
        assign res_a[gi]   = bus.o_result;
        assign wb_a[gi]    = bus.o_WB_control;
    end

    int checks = 0;
    int errors = 0;
    int sel = 0;
    logic [7:0] ref_mem [1024];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (lat %0d): got %h expected %h", name, sel + 1, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input int a, input logic [1:0] size, input logic uns);
        int v;
        if (size == 2'b00) begin
            v = ref_mem[a];
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 2'b01) begin
            v = ref_mem[a] + 256 * ref_mem[a + 1];
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            return {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
        end
        return 32'(v);
    endfunction

    task automatic model_store(input int a, input logic [1:0] size, input logic [31:0] d);
        int n;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) ref_mem[a + k] = 8'(d >> (8 * k));
    endtask

    function automatic op_t mk(input logic v, input logic [2:0] mctl, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] data,
                               input logic zero);
        op_t o;
        o.valid = v; o.mctl = mctl; o.size = size; o.uns = uns; o.addr = addr;
        o.data = data; o.zero = zero; o.wreg = 5'd7; o.wb = 2'b11; o.bpc = 32'h40;
        return o;
    endfunction

    function automatic vec_t vv(input op_t o, input logic mis, input logic br, input logic v,
                                input logic [31:0] wd, input int st);
        vec_t r;
        r.op = o; r.exp_mis = mis; r.exp_br = br; r.exp_valid = v; r.exp_wd = wd; r.exp_st = st;
        return r;
    endfunction

    // Called at a falling edge; returns at a falling edge after the op retires.
    task automatic do_op(input op_t op, output logic [31:0] got_wd, output logic got_valid,
                         output logic got_mis, output logic got_br, output int got_stalls);
        logic rd, wr, acc, mis, memop, st, done;
        int a, lat, exp_st;
        logic [31:0] exp_wd;
        lat    = sel + 1;
        rd     = op.mctl[1];
        wr     = op.mctl[2];
        acc    = op.valid && (rd || wr);
        a      = int'(op.addr[9:0]);
        mis    = acc && ((op.size == 2'b01 && a % 2 != 0) || (op.size[1] && a % 4 != 0));
        memop  = acc && !mis;
        exp_st = (memop && lat > 1) ? lat - 1 : 0;
        exp_wd = (memop && rd && !wr) ? model_load(a, op.size, op.uns) : 32'd0;

        t_valid = op.valid; t_mctl = op.mctl; t_size = op.size; t_uns = op.uns;
        t_result = op.addr; t_data = op.data; t_zero = op.zero; t_wreg = op.wreg;
        t_wb = op.wb; t_bpc = op.bpc;
        #1;
        got_mis = mis_a[sel];
        got_br  = br_a[sel];
        check("misalign", 32'(got_mis), 32'(mis));
        check("branch", 32'(got_br), 32'(op.valid & op.mctl[0] & op.zero));
        check("branch_pc", bpc_a[sel], op.bpc);

        got_stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 16 && !done; c++) begin
            st = stall_a[sel];
            @(posedge clk);
            #1;
            if (st) begin
                got_stalls++;
                check("bubble_valid", 32'(valid_a[sel]), 32'd0);
                check("bubble_wb", 32'(wb_a[sel]), 32'd0);
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout (lat %0d): got stalled expected done", lat);
        end
        check("stall_cycles", 32'(got_stalls), 32'(exp_st));
        got_valid = valid_a[sel];
        got_wd    = wd_a[sel];
        check("o_valid", 32'(got_valid), 32'(op.valid && !mis));
        if (mis) begin
            check("bubble_wd", got_wd, 32'd0);
            check("bubble_res", res_a[sel], 32'd0);
            check("bubble_wreg", 32'(wreg_a[sel]), 32'd0);
        end else if (op.valid) begin
            check("write_data", got_wd, exp_wd);
            check("result", res_a[sel], op.addr);
            check("write_reg", 32'(wreg_a[sel]), 32'(op.wreg));
            check("wb_control", 32'(wb_a[sel]), 32'(op.wb));
        end
        if (memop && wr) model_store(a, op.size, op.data);
        @(negedge clk);
    endtask

    task automatic do_reset();
        t_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic op_t rand_op();
        op_t o;
        o.valid = ($urandom_range(0, 7) != 0);
        o.mctl  = 3'($urandom_range(0, 7));
        o.size  = 2'($urandom_range(0, 3));
        o.uns   = 1'($urandom_range(0, 1));
        o.addr  = {22'($urandom), 10'($urandom_range(0, 63))};
        o.data  = $urandom;
        o.zero  = 1'($urandom_range(0, 1));
        o.wreg  = 5'($urandom);
        o.wb    = 2'($urandom);
        o.bpc   = $urandom;
        return o;
    endfunction

    vec_t vt [23];
    logic [31:0] g_wd;
    logic g_v, g_m, g_b;
    int g_st;

    initial begin
        t_valid = 0; t_mctl = 0; t_size = 0; t_uns = 0; t_result = 0;
        t_data = 0; t_zero = 0; t_wreg = 0; t_wb = 0; t_bpc = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;

        vt[0]  = vv(mk(1, 3'b100, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0), 0, 0, 1, 32'h0, 1);
        vt[1]  = vv(mk(1, 3'b010, 2'b10, 0, 32'h10, 32'h0, 0), 0, 0, 1, 32'hDEADBEEF, 1);
        vt[2]  = vv(mk(1, 3'b100, 2'b10, 0, 32'h10, 32'hAAAAAAAA, 0), 0, 0, 1, 32'h0, 1);
        vt[3]  = vv(mk(1, 3'b100, 2'b01, 0, 32'h12, 32'h55551234, 0), 0, 0, 1, 32'h0, 1);
        vt[4]  = vv(mk(1, 3'b010, 2'b10, 0, 32'h10, 32'h0, 0), 0, 0, 1, 32'h1234AAAA, 1);
        vt[5]  = vv(mk(1, 3'b100, 2'b00, 0, 32'h13, 32'h00000080, 0), 0, 0, 1, 32'h0, 1);
        vt[6]  = vv(mk(1, 3'b010, 2'b00, 0, 32'h13, 32'h0, 0), 0, 0, 1, 32'hFFFFFF80, 1);
        vt[7]  = vv(mk(1, 3'b010, 2'b00, 1, 32'h13, 32'h0, 0), 0, 0, 1, 32'h00000080, 1);
        vt[8]  = vv(mk(1, 3'b010, 2'b10, 0, 32'h06, 32'h0, 0), 1, 0, 0, 32'h0, 0);
        vt[9]  = vv(mk(1, 3'b100, 2'b10, 0, 32'h11, 32'hFFFFFFFF, 0), 1, 0, 0, 32'h0, 0);
        vt[10] = vv(mk(1, 3'b010, 2'b10, 0, 32'h10, 32'h0, 0), 0, 0, 1, 32'h8034AAAA, 1);
        vt[11] = vv(mk(1, 3'b001, 2'b10, 0, 32'h0, 32'h0, 1), 0, 1, 1, 32'h0, 0);
        vt[12] = vv(mk(0, 3'b001, 2'b10, 0, 32'h0, 32'h0, 1), 0, 0, 0, 32'h0, 0);
        vt[13] = vv(mk(1, 3'b001, 2'b10, 0, 32'h0, 32'h0, 0), 0, 0, 1, 32'h0, 0);
        vt[14] = vv(mk(1, 3'b010, 2'b01, 0, 32'h12, 32'h0, 0), 0, 0, 1, 32'hFFFF8034, 1);
        vt[15] = vv(mk(1, 3'b010, 2'b01, 1, 32'h12, 32'h0, 0), 0, 0, 1, 32'h00008034, 1);
        vt[16] = vv(mk(1, 3'b010, 2'b01, 0, 32'h13, 32'h0, 0), 1, 0, 0, 32'h0, 0);
        vt[17] = vv(mk(1, 3'b110, 2'b10, 0, 32'h10, 32'h11223344, 0), 0, 0, 1, 32'h0, 1);
        vt[18] = vv(mk(1, 3'b010, 2'b11, 0, 32'h10, 32'h0, 0), 0, 0, 1, 32'h11223344, 1);
        vt[19] = vv(mk(1, 3'b010, 2'b10, 0, 32'h410, 32'h0, 0), 0, 0, 1, 32'h11223344, 1);
        vt[20] = vv(mk(0, 3'b100, 2'b10, 0, 32'h10, 32'h0, 0), 0, 0, 0, 32'h0, 0);
        vt[21] = vv(mk(1, 3'b010, 2'b10, 0, 32'h10, 32'h0, 0), 0, 0, 1, 32'h11223344, 1);
        vt[22] = vv(mk(1, 3'b010, 2'b10, 0, 32'hFFFF_FC10, 32'h0, 0), 0, 0, 1, 32'h11223344, 1);

        // Reset state of every instance.
        @(negedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            sel = d;
            check("rst_valid", 32'(valid_a[d]), 32'd0);
            check("rst_wd", wd_a[d], 32'd0);
            check("rst_res", res_a[d], 32'd0);
            check("rst_stall", 32'(stall_a[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table on the two-cycle-latency instance.
        sel = 1;
        do_reset();
        for (int i = 0; i < 23; i++) begin
            do_op(vt[i].op, g_wd, g_v, g_m, g_b, g_st);
            $display("vec %0d: valid=%0d wd=%h mis=%0d br=%0d stalls=%0d", i, g_v, g_wd, g_m, g_b, g_st);
            check("tbl_mis", 32'(g_m), 32'(vt[i].exp_mis));
            check("tbl_br", 32'(g_b), 32'(vt[i].exp_br));
            check("tbl_valid", 32'(g_v), 32'(vt[i].exp_valid));
            check("tbl_wd", g_wd, vt[i].exp_wd);
            check("tbl_stalls", 32'(g_st), 32'(vt[i].exp_st));
        end

        // Three-cycle byte loads of 0x80.
        sel = 2;
        do_reset();
        do_op(mk(1, 3'b100, 2'b00, 0, 32'h13, 32'h80, 0), g_wd, g_v, g_m, g_b, g_st);
        do_op(mk(1, 3'b010, 2'b00, 0, 32'h13, 32'h0, 0), g_wd, g_v, g_m, g_b, g_st);
        $display("lat3 signed byte load: wd=%h stalls=%0d", g_wd, g_st);
        check("lat3_signed", g_wd, 32'hFFFFFF80);
        check("lat3_stalls", 32'(g_st), 32'd2);
        do_op(mk(1, 3'b010, 2'b00, 1, 32'h13, 32'h0, 0), g_wd, g_v, g_m, g_b, g_st);
        $display("lat3 unsigned byte load: wd=%h stalls=%0d", g_wd, g_st);
        check("lat3_unsigned", g_wd, 32'h00000080);

        // Reset clears a live MEM/WB entry and aborts an in-flight store.
        sel = 3;
        do_reset();
        do_op(mk(1, 3'b100, 2'b10, 0, 32'h20, 32'h5A5A5A5A, 0), g_wd, g_v, g_m, g_b, g_st);
        do_op(mk(1, 3'b000, 2'b10, 0, 32'h1234, 32'h0, 0), g_wd, g_v, g_m, g_b, g_st);
        rst_n = 1'b0;
        #1;
        $display("reset after alu op: valid=%0d result=%h", valid_a[3], res_a[3]);
        check("rst_live_valid", 32'(valid_a[3]), 32'd0);
        check("rst_live_result", res_a[3], 32'd0);
        check("rst_live_wb", 32'(wb_a[3]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        t_valid = 1; t_mctl = 3'b100; t_size = 2'b10; t_result = 32'h20; t_data = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(valid_a[3]), 32'd0);
        check("abort_wd", wd_a[3], 32'd0);
        check("abort_wreg", 32'(wreg_a[3]), 32'd0);
        t_valid = 1'b0;
        #1;
        check("abort_stall", 32'(stall_a[3]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(mk(1, 3'b010, 2'b10, 0, 32'h20, 32'h0, 0), g_wd, g_v, g_m, g_b, g_st);
        $display("after abort word load 0x20: wd=%h stalls=%0d", g_wd, g_st);
        check("abort_mem_kept", g_wd, 32'h5A5A5A5A);

        // Random ops per latency after seeding the address window.
        for (int d = 0; d < NDUT; d++) begin
            sel = d;
            do_reset();
            for (int w = 0; w < 16; w++)
                do_op(mk(1, 3'b100, 2'b10, 0, 32'(4 * w), $urandom, 0), g_wd, g_v, g_m, g_b, g_st);
            for (int n = 0; n < 150; n++) begin
                op_t r;
                r = rand_op();
                do_op(r, g_wd, g_v, g_m, g_b, g_st);
                $display("rand lat%0d #%0d: v=%0d mctl=%b size=%b addr=%h -> valid=%0d wd=%h stalls=%0d",
                         d + 1, n, r.valid, r.mctl, r.size, r.addr, g_v, g_wd, g_st);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
